// File: rtl/car_motion_monitor.sv
// Power/motion state tracker for the simulated car: mileage accumulation while
// moving, blinking turn lights and a forward/backward conflict flag.
module car_motion_monitor #(
  parameter int MILE_TICKS  = 10000000,
  parameter int BLINK_TICKS = 50000000,
  parameter int MILEAGE_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power_on,
  input  logic                 break_in,
  input  logic                 move_forward,
  input  logic                 move_backward,
  input  logic                 turn_left,
  input  logic                 turn_right,
  output logic                 powered,
  output logic [1:0]           moving_state,
  output logic [MILEAGE_W-1:0] mileage,
  output logic                 left_light,
  output logic                 right_light,
  output logic                 conflict
);

  localparam int TICK_W  = $clog2(MILE_TICKS);
  localparam int BLINK_W = $clog2(BLINK_TICKS);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(MILE_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_IDLE = 2'b01,
    ST_FWD  = 2'b10,
    ST_BWD  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    BL_NONE  = 2'b00,
    BL_LEFT  = 2'b01,
    BL_RIGHT = 2'b10
  } blink_t;

  state_t             state, state_next;
  blink_t             blink_dir, blink_req;
  logic [TICK_W-1:0]  tick_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               fwd_only, bwd_only;
  logic               moving_now, moving_next;
  logic               lights_enabled;

  assign fwd_only       = move_forward & ~move_backward;
  assign bwd_only       = move_backward & ~move_forward;
  assign moving_now     = (state == ST_FWD) || (state == ST_BWD);
  assign moving_next    = (state_next == ST_FWD) || (state_next == ST_BWD);
  assign lights_enabled = (state != ST_OFF) && (state_next != ST_OFF);
  assign moving_state   = state;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (state == ST_OFF) begin
      if (power_on) state_next = ST_IDLE;
    end else if (break_in) begin
      state_next = ST_OFF;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fwd_only)      state_next = ST_FWD;
          else if (bwd_only) state_next = ST_BWD;
        end
        // Reversal never skips IDLE: anything but the held direction drops out.
        ST_FWD:  if (!fwd_only) state_next = ST_IDLE;
        ST_BWD:  if (!bwd_only) state_next = ST_IDLE;
        default: state_next = ST_OFF;
      endcase
    end
  end

  always_comb begin
    blink_req = BL_NONE;
    if (turn_left && !turn_right)      blink_req = BL_LEFT;
    else if (turn_right && !turn_left) blink_req = BL_RIGHT;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_OFF;
      powered     <= 1'b0;
      conflict    <= 1'b0;
      mileage     <= '0;
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      blink_dir   <= BL_NONE;
      left_light  <= 1'b0;
      right_light <= 1'b0;
    end else begin
      state    <= state_next;
      powered  <= (state_next != ST_OFF);
      conflict <= lights_enabled && move_forward && move_backward;

      // Distance: a full MILE_TICKS run of uninterrupted motion earns one unit.
      if (!moving_next) begin
        tick_cnt <= '0;
      end else if (moving_now) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          if (mileage != {MILEAGE_W{1'b1}}) mileage <= mileage + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      if (state == ST_OFF && power_on) mileage <= '0;

      if (!lights_enabled || blink_req == BL_NONE) begin
        blink_dir   <= BL_NONE;
        blink_cnt   <= '0;
        left_light  <= 1'b0;
        right_light <= 1'b0;
      end else if (blink_req != blink_dir) begin
        // New or switched direction restarts the phase with the light on.
        blink_dir   <= blink_req;
        blink_cnt   <= '0;
        left_light  <= (blink_req == BL_LEFT);
        right_light <= (blink_req == BL_RIGHT);
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        if (blink_dir == BL_LEFT) left_light  <= ~left_light;
        else                      right_light <= ~right_light;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
